transport_send_sched: RTL

Transport-layer transmit scheduler that shares the single outbound byte link to the network layer between two session-side requesters: the control-command path and the audio stream. It arbitrates between the two and frames each granted packet as header, payload and 8'hFF trailer. It also sequences reads from the audio word FIFO. The framing matches what the transport receiver parses: 8'h80 header for audio, 8'h40 header for control.

---
 rtl/transport_send_sched.sv | 139 +++++++++++++
 1 files changed

// File: rtl/transport_send_sched.sv
// Transmit scheduler: arbitrates control and audio requesters onto one
// byte link, framing each packet as header, payload and 8'hFF trailer.
module transport_send_sched #(
  parameter int AUDIO_WORDS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ctrlReq,
  input  logic [7:0]  ctrlCmd,
  output logic        ctrlAck,
  input  logic        audioReq,
  output logic        audioRd,
  input  logic [15:0] audioData,
  input  logic        netBusy,
  output logic        sendSignal,
  output logic [7:0]  packetOut,
  output logic [1:0]  grant
);

  localparam int CW = $clog2(AUDIO_WORDS + 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    CTRL_BYTE,
    AUD_HI,
    AUD_LO,
    TRAIL
  } state_t;

  state_t        state_q, state_d;
  logic          aud_q, aud_d;
  logic          last_q, last_d;
  logic          ack_q, ack_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    word_q, word_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          pick_ctrl;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      aud_q   <= 1'b0;
      last_q  <= 1'b1;
      ack_q   <= 1'b0;
      cmd_q   <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      aud_q   <= aud_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      cmd_q   <= cmd_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
    end
  end

  // last_q=1 means audio had the previous grant
  assign pick_ctrl = ctrlReq && (!audioReq || last_q);
  assign cnt_inc   = cnt_q + CW'(1);
  assign ctrlAck   = ack_q;

  always_comb begin
    state_d    = state_q;
    aud_d      = aud_q;
    last_d     = last_q;
    ack_d      = 1'b0;
    cmd_d      = cmd_q;
    word_d     = word_q;
    cnt_d      = cnt_q;
    sendSignal = 1'b0;
    packetOut  = 8'h00;
    audioRd    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!netBusy && (ctrlReq || audioReq)) begin
          state_d = HDR;
          if (pick_ctrl) begin
            aud_d = 1'b0;
            cmd_d = ctrlCmd;
            ack_d = 1'b1;
          end else begin
            aud_d = 1'b1;
          end
        end
      end
      HDR: begin
        sendSignal = 1'b1;
        cnt_d      = '0;
        if (aud_q) begin
          packetOut = 8'h80;
          audioRd   = 1'b1;
          state_d   = AUD_HI;
        end else begin
          packetOut = 8'h40;
          state_d   = CTRL_BYTE;
        end
      end
      CTRL_BYTE: begin
        sendSignal = 1'b1;
        packetOut  = cmd_q;
        state_d    = TRAIL;
      end
      AUD_HI: begin
        sendSignal = 1'b1;
        packetOut  = audioData[15:8];
        word_d     = audioData[7:0];
        state_d    = AUD_LO;
      end
      AUD_LO: begin
        sendSignal = 1'b1;
        packetOut  = word_q;
        cnt_d      = cnt_inc;
        if (cnt_inc < CW'(AUDIO_WORDS)) begin
          audioRd = 1'b1;
          state_d = AUD_HI;
        end else begin
          state_d = TRAIL;
        end
      end
      TRAIL: begin
        sendSignal = 1'b1;
        packetOut  = 8'hFF;
        last_d     = aud_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant = 2'b00;
    if (state_q != IDLE) grant = aud_q ? 2'b10 : 2'b01;
  end

endmodule
